// File: rtl/secure_enc_pkg.sv
// secure_enc_pkg: shared state type and width helpers for the secure Hamming encoder
package secure_enc_pkg;

    typedef enum logic [1:0] {LOCKED, COLLECT, UNLOCKED, LOCKOUT} state_e;

    function automatic int parity_bits(input int data_w);
        int p;
        p = 1;
        while ((1 << p) < data_w + p + 1) p++;
        return p;
    endfunction

    function automatic int enc_width(input int data_w, input int secded);
        return data_w + parity_bits(data_w) + secded;
    endfunction

    function automatic logic is_pow2(input int pos);
        return pos > 0 && (pos & (pos - 1)) == 0;
    endfunction

endpackage

// File: rtl/hamming_enc_core.sv
// hamming_enc_core: combinational data -> Hamming SEC / SEC-DED codeword
module hamming_enc_core
    import secure_enc_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int SECDED = 1
) (
    input  logic [DATA_W-1:0]                    data_in,
    output logic [enc_width(DATA_W, SECDED)-1:0] enc_out
);

    localparam int P = parity_bits(DATA_W);
    localparam int N = DATA_W + P;

    // data fills non-power-of-two positions LSB first; each parity covers positions with its bit set
    function automatic logic [N-1:0] hamming(input logic [DATA_W-1:0] d);
        logic [N-1:0] c;
        int j;
        c = '0;
        j = 0;
        for (int p = 1; p <= N; p++)
            if (!is_pow2(p)) begin
                c[p-1] = d[j];
                j++;
            end
        for (int k = 0; k < P; k++)
            for (int p = 1; p <= N; p++)
                if (p[k] && !is_pow2(p)) c[(1 << k) - 1] ^= c[p-1];
        return c;
    endfunction

    logic [N-1:0] sec;

    assign sec = hamming(data_in);

    if (SECDED != 0) begin : g_secded
        assign enc_out = {^sec, sec};
    end else begin : g_sec
        assign enc_out = sec;
    end

endmodule

// File: rtl/secure_hamming_encoder.sv
// secure_hamming_encoder: serial-code unlock with lockout, then registered Hamming encode
module secure_hamming_encoder
    import secure_enc_pkg::*;
#(
    parameter int                  DATA_W      = 4,
    parameter int                  SECDED      = 1,
    parameter int                  CODE_LEN    = 4,
    parameter logic [CODE_LEN-1:0] CODE        = 4'b1011,
    parameter int                  MAX_FAIL    = 3,
    parameter int                  LOCK_CYCLES = 16,
    parameter int                  SESSION     = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 code_valid,
    input  logic                                 code_bit,
    input  logic                                 relock,
    input  logic                                 data_valid,
    input  logic [DATA_W-1:0]                    data_in,
    output logic                                 data_ready,
    output logic                                 enc_valid,
    output logic [enc_width(DATA_W, SECDED)-1:0] enc_out,
    input  logic                                 enc_ready,
    output logic                                 unlocked,
    output logic                                 locked_out,
    output logic [$clog2(MAX_FAIL+1)-1:0]        fail_cnt
);

    localparam int ENC_W = enc_width(DATA_W, SECDED);
    localparam int FW    = $clog2(MAX_FAIL + 1);
    localparam int CW    = $clog2(CODE_LEN + 1);
    localparam int TW    = $clog2(LOCK_CYCLES + 1);

    state_e              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [CODE_LEN-1:0] sr, sr_n;
    logic [FW-1:0]       fail_n, fail_inc;
    logic [TW-1:0]       timer, timer_n;
    logic [ENC_W-1:0]    code;
    logic                accept;

    hamming_enc_core #(.DATA_W(DATA_W), .SECDED(SECDED)) u_core (
        .data_in (data_in),
        .enc_out (code)
    );

    assign unlocked   = state == UNLOCKED;
    assign locked_out = state == LOCKOUT;
    assign data_ready = unlocked & ~relock & (~enc_valid | enc_ready);
    assign accept     = data_valid & data_ready;
    assign fail_inc   = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;

    // a full window is compared one cycle after its last bit lands in sr
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        fail_n  = fail_cnt;
        timer_n = timer;
        case (state)
            LOCKED:
                if (relock) cnt_n = '0;
                else if (code_valid) begin
                    sr_n    = CODE_LEN'({sr, code_bit});
                    cnt_n   = CW'(1);
                    state_n = COLLECT;
                end
            COLLECT:
                if (relock) begin
                    cnt_n   = '0;
                    state_n = LOCKED;
                end else if (cnt == CW'(CODE_LEN)) begin
                    cnt_n   = '0;
                    fail_n  = (sr == CODE) ? '0 : fail_inc;
                    state_n = (sr == CODE) ? UNLOCKED : (fail_inc == FW'(MAX_FAIL)) ? LOCKOUT : LOCKED;
                end else if (code_valid) begin
                    sr_n  = CODE_LEN'({sr, code_bit});
                    cnt_n = cnt + 1'b1;
                end
            UNLOCKED:
                state_n = (relock || (SESSION == 0 && accept)) ? LOCKED : UNLOCKED;
            LOCKOUT:
                if (timer == TW'(LOCK_CYCLES - 1)) begin
                    timer_n = '0;
                    fail_n  = '0;
                    state_n = LOCKED;
                end else timer_n = timer + 1'b1;
            default:
                state_n = LOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOCKED;
            cnt       <= '0;
            sr        <= '0;
            fail_cnt  <= '0;
            timer     <= '0;
            enc_valid <= 1'b0;
            enc_out   <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sr       <= sr_n;
            fail_cnt <= fail_n;
            timer    <= timer_n;
            if (accept) begin
                enc_valid <= 1'b1;
                enc_out   <= code;
            end else if (enc_ready) enc_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_secure_hamming_encoder.sv
// tb_secure_hamming_encoder: randomized self-checking bench with a positional Hamming reference model
module tb_secure_hamming_encoder;
    import secure_enc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       cv = 0, cb = 0, rl = 0, dv = 0, er = 0;
    logic [3:0] di = 0;
    logic       dr, ev, ul, lo;
    logic [7:0] eo;
    logic [1:0] fc;

    logic       cv_s = 0, cb_s = 0, rl_s = 0, dv_s = 0, er_s = 0;
    logic [3:0] di_s = 0;
    logic       dr_s, ev_s, ul_s, lo_s;
    logic [7:0] eo_s;
    logic [1:0] fc_s;

    logic [25:0] sw_d = 0;
    logic [31:0] sw_e [1:26];

    int n_vec = 0, n_err = 0;

    secure_hamming_encoder u_dut (
        .clk(clk), .rst(rst), .code_valid(cv), .code_bit(cb), .relock(rl),
        .data_valid(dv), .data_in(di), .data_ready(dr), .enc_valid(ev), .enc_out(eo),
        .enc_ready(er), .unlocked(ul), .locked_out(lo), .fail_cnt(fc)
    );

    secure_hamming_encoder #(.SESSION(1)) u_dut_s (
        .clk(clk), .rst(rst), .code_valid(cv_s), .code_bit(cb_s), .relock(rl_s),
        .data_valid(dv_s), .data_in(di_s), .data_ready(dr_s), .enc_valid(ev_s), .enc_out(eo_s),
        .enc_ready(er_s), .unlocked(ul_s), .locked_out(lo_s), .fail_cnt(fc_s)
    );

    for (genvar j = 1; j <= 26; j++) begin : g_sw
        localparam int W = enc_width(j, 1);
        logic [W-1:0] e;
        hamming_enc_core #(.DATA_W(j), .SECDED(1)) u_core (.data_in(sw_d[j-1:0]), .enc_out(e));
        assign sw_e[j] = 32'(e);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference: data bit i goes to the i-th non-power-of-two position; the parity
    // word is the XOR of the position numbers of all set data bits, overall bit on top
    function automatic logic [31:0] ref_enc(input logic [25:0] d, input int dw);
        logic [31:0] c;
        int pos, s;
        c = '0;
        pos = 0;
        s = 0;
        for (int i = 0; i < dw; i++) begin
            pos++;
            while ((pos & (pos - 1)) == 0) pos++;
            if (d[i]) begin
                c[pos-1] = 1'b1;
                s ^= pos;
            end
        end
        for (int k = 0; (1 << k) <= pos; k++) c[(1 << k) - 1] = s[k];
        c[pos] = ^c;
        return c;
    endfunction

    function automatic int syn(input logic [31:0] c, input int n);
        int s;
        s = 0;
        for (int p = 1; p <= n; p++) if (c[p-1]) s ^= p;
        return s;
    endfunction

    task automatic send_code(input bit s, input logic [3:0] code);
        for (int i = 3; i >= 0; i--) begin
            if (s) begin cv_s = 1; cb_s = code[i]; end
            else begin cv = 1; cb = code[i]; end
            step();
        end
        cv = 0;
        cv_s = 0;
    endtask

    task automatic unlock(input bit s);
        send_code(s, 4'b1011);
        step();
        check(s ? "unlock_s" : "unlock", s ? ul_s : ul, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] w, h;
        logic [3:0] good = 4'b1011;
        logic [31:0] c;
        int n;
        #2;
        check("reset_a", {ul, lo, fc, ev, dr, eo}, 0);
        check("reset_s", {ul_s, lo_s, fc_s, ev_s, dr_s, eo_s}, 0);
        step();
        rst = 1;
        step();
        // basic unlock and one word, SESSION=0 auto-lock
        send_code(0, good);
        check("latency_pre", ul, 0);
        step();
        check("unlock_first", ul, 1);
        di = 4'b1011; dv = 1; er = 1;
        #1;
        check("ready_first", dr, 1);
        step();
        dv = 0;
        check("enc_55", eo, 8'h55);
        check("ev_first", ev, 1);
        check("autolock", ul, 0);
        step();
        check("drain", ev, 0);
        // backpressure holds the codeword
        unlock(0);
        er = 0; di = 4'b0001; dv = 1;
        step();
        dv = 0;
        for (int i = 0; i < 5; i++) begin
            check("hold_ev", ev, 1);
            check("hold_87", eo, 8'h87);
            check("hold_ready", dr, 0);
            step();
        end
        er = 1;
        step();
        check("hold_drain", ev, 0);
        // brute-force lockout
        for (int k = 1; k <= 3; k++) begin
            w = (k == 1) ? 4'b1111 : 4'($urandom_range(0, 15));
            if (w == good) w = 4'b0000;
            send_code(0, w);
            step();
            check("fail_cnt", fc, k);
            check("lockout_flag", lo, k == 3);
        end
        for (int o = 1; o <= 15; o++) begin
            cv = o <= 4;
            cb = (o <= 4) ? good[4-o] : 1'b0;
            step();
            check("lockout_hold", lo, 1);
            check("lockout_nounlock", ul, 0);
        end
        cv = 0;
        step();
        check("lockout_expire", lo, 0);
        check("lockout_fail_clr", fc, 0);
        check("lockout_ignored", ul, 0);
        unlock(0);
        dv = 1; di = 4'($urandom); rl = 1;
        #1;
        check("relock_ready", dr, 0);
        step();
        rl = 0; dv = 0;
        check("relock_ul", ul, 0);
        check("relock_noword", ev, 0);
        // random words through the reference model
        for (int i = 0; i < 6; i++) begin
            unlock(0);
            w = 4'($urandom);
            di = w; dv = 1;
            step();
            dv = 0;
            check("rand_enc", eo, ref_enc(26'(w), 4));
            check("rand_ev", ev, 1);
            step();
        end
        // relock in COLLECT keeps fail_cnt, reset clears everything
        send_code(0, 4'b1111);
        step();
        check("fail_one", fc, 1);
        cv = 1; cb = 1; step(); cb = 0; step(); cv = 0;
        rl = 1; step(); rl = 0;
        check("relock_keep_fail", fc, 1);
        cv = 1; cb = 1; step(); cb = 0; step(); cv = 0;
        rst = 0;
        #1;
        check("rst_collect", {ul, lo, fc, ev, dr, eo}, 0);
        step();
        rst = 1;
        step();
        cv = 1; cb = 1; step(); step(); cv = 0; step();
        check("partial_locked", ul, 0);
        rl = 1; step(); rl = 0;
        unlock(0);
        er = 0; di = 4'($urandom); dv = 1;
        step();
        dv = 0;
        check("predrain_ev", ev, 1);
        rst = 0;
        #1;
        check("rst_drain", {ul, lo, fc, ev, dr, eo}, 0);
        step();
        rst = 1; er = 1;
        step();
        unlock(0);
        rl = 1; step(); rl = 0;
        // SESSION=1: back-to-back words
        unlock(1);
        er_s = 1;
        for (int k = 0; k < 4; k++) begin
            w = 4'($urandom);
            di_s = w; dv_s = 1;
            #1;
            check("s_ready", dr_s, 1);
            step();
            check("s_ev", ev_s, 1);
            check("s_enc", eo_s, ref_enc(26'(w), 4));
        end
        dv_s = 0;
        check("s_stay_unlocked", ul_s, 1);
        step();
        check("s_drain", ev_s, 0);
        er_s = 0; h = 4'($urandom); di_s = h; dv_s = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            di_s = 4'($urandom);
            #1;
            check("s_block_ready", dr_s, 0);
            check("s_block_ev", ev_s, 1);
            check("s_block_enc", eo_s, ref_enc(26'(h), 4));
            step();
        end
        dv_s = 0; er_s = 1;
        step();
        check("s_block_drain", ev_s, 0);
        dv_s = 1; rl_s = 1;
        #1;
        check("s_relock_ready", dr_s, 0);
        step();
        rl_s = 0; dv_s = 0;
        check("s_relock_ul", ul_s, 0);
        check("s_relock_noword", ev_s, 0);
        // width sweep of the encoder core
        for (int t = 0; t < 3; t++) begin
            sw_d = 26'($urandom);
            #1;
            for (int j = 1; j <= 26; j++) begin
                n = j + parity_bits(j);
                c = sw_e[j];
                check("sw_enc", c, ref_enc(sw_d, j));
                check("sw_syn", syn(c, n), 0);
                check("sw_parity", ^c, 0);
                if (t == 0)
                    for (int p = 1; p <= n; p++)
                        check("sw_flip", syn(c ^ (32'd1 << (p - 1)), n), p);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
